// File: rtl/axis_src_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the source arbiter and its output stage.
//   arb_state_t : arbiter FSM encoding (IDLE, GRANT)
//   MAX_SRC     : largest supported source count; rr_pick works on this width
//   rr_pick     : round-robin pick of the first request at or above a pointer,
//                 wrapping to the lowest request when none is found above it
// -----------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_SRC   = 16;
    localparam int PICK_W    = 4;

    // Callers zero-extend their request vector to MAX_SRC bits, so unused upper
    // bits never match and the loop serves any source count from 2 to 16.
    function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                  input logic [PICK_W-1:0]  ptr);
        logic              found;
        logic [PICK_W-1:0] pick;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                pick  = PICK_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < MAX_SRC; i++) begin
            if (!found && req[i]) begin
                pick  = PICK_W'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_src_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_src_arbiter_if
// Bundles the N source streams, the per-source enables and the shared output
// stream of the source arbiter.
//   s_axis_tdata/tvalid/tready : N packed source streams (source i in slice i)
//   src_en                     : per-source enable
//   m_axis_tdata/tid/tvalid/tready : merged, source-tagged output stream
//   busy                       : arbiter holds a grant or a buffered beat
// Modports:
//   slave  : the arbiter side (consumes sources, produces the merged stream)
//   master : the environment side (produces sources, consumes the stream)
// -----------------------------------------------------------------------------
interface axis_src_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]            s_axis_tvalid;
    logic [NUM_SRC-1:0]            s_axis_tready;
    logic [NUM_SRC-1:0]            src_en;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic [ID_WIDTH-1:0]           m_axis_tid;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          busy;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, src_en, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid, busy
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, src_en, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid, busy
    );

endinterface

// File: rtl/axis_src_arbiter_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// One-entry registered output stage with a load/drain handshake.
//   clk, rst      : clock and synchronous active-high reset
//   load          : capture load_data/load_id this cycle (caller guarantees
//                   the stage is free or draining)
//   load_data/id  : beat and tag to capture
//   tdata/tid     : registered beat and tag, stable while tvalid & ~tready
//   tvalid        : registered valid
//   tready        : downstream ready
// A load in the same cycle as a drain reloads the stage and keeps tvalid high.
// -----------------------------------------------------------------------------
module axis_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ID_WIDTH-1:0]   load_id,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic [ID_WIDTH-1:0]   tid,
    output logic                  tvalid,
    input  logic                  tready
);

    logic [DATA_WIDTH-1:0] data_p1;
    logic [ID_WIDTH-1:0]   id_p1;
    logic                  vld_p1;

    // ---- output stage register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            id_p1   <= '0;
            vld_p1  <= 1'b0;
        end else if (load) begin
            data_p1 <= load_data;
            id_p1   <= load_id;
            vld_p1  <= 1'b1;
        end else if (vld_p1 && tready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign tdata  = data_p1;
    assign tid    = id_p1;
    assign tvalid = vld_p1;

endmodule

// File: rtl/axis_src_arbiter.sv
// -----------------------------------------------------------------------------
// axis_src_arbiter
// Round-robin, burst-limited arbiter merging NUM_SRC AXI-stream sources onto a
// single registered output tagged with the source index.
//   s_axis_aclk   : clock
//   s_axis_areset : synchronous active-high reset
//   axis          : source streams, enables and merged output (slave modport)
// Parameters: DATA_WIDTH beat width, NUM_SRC sources (2..16), MAX_BURST beats
// per grant (1..256).
// Arbitration takes one IDLE cycle; a grant then lasts until MAX_BURST beats
// are taken or the granted source stops offering / is disabled.
// -----------------------------------------------------------------------------
module axis_src_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_areset,
    axis_src_arbiter_if.slave  axis
);
    import axis_arb_pkg::*;

    localparam int ID_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_GRANT = GRANT;

    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_SRC - 1);
    localparam logic [7:0]          LAST_BEAT = 8'(MAX_BURST - 1);

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [7:0]            beat_cnt;

    logic [NUM_SRC-1:0]    req;
    logic [ID_WIDTH-1:0]   pick_id;
    logic                  g_vld;
    logic                  g_en;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  out_vld;
    logic                  free;
    logic                  grant_ok;
    logic                  accept;
    logic                  rel_grant;
    logic [NUM_SRC-1:0]    ready;

    // ---- request / select ----
    assign req     = axis.s_axis_tvalid & axis.src_en;
    assign pick_id = ID_WIDTH'(rr_pick(MAX_SRC'(req), PICK_W'(rr_ptr)));

    // Compare-based mux so a non-power-of-two source count never indexes
    // past the packed vectors.
    always_comb begin
        g_vld  = 1'b0;
        g_en   = 1'b0;
        g_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(grant_id) == i) begin
                g_vld  = axis.s_axis_tvalid[i];
                g_en   = axis.src_en[i];
                g_data = axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_vld = axis.m_axis_tvalid;
    assign free    = ~out_vld | axis.m_axis_tready;

    // Ready never looks at tvalid; reset forces it low in the reset cycle.
    assign grant_ok = (state == S_GRANT) & ~s_axis_areset & free & g_en;

    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(grant_id) == i) begin
                ready[i] = grant_ok;
            end
        end
    end

    assign axis.s_axis_tready = ready;

    assign accept    = grant_ok & g_vld;
    assign rel_grant = (state == S_GRANT) &
                       ((accept & (beat_cnt == LAST_BEAT)) | ~g_vld | ~g_en);

    // ---- arbiter FSM ----
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state    <= S_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state    <= S_GRANT;
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (rel_grant) begin
                        state  <= S_IDLE;
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- output stage ----
    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_out_reg (
        .clk       (s_axis_aclk),
        .rst       (s_axis_areset),
        .load      (accept),
        .load_data (g_data),
        .load_id   (grant_id),
        .tdata     (axis.m_axis_tdata),
        .tid       (axis.m_axis_tid),
        .tvalid    (axis.m_axis_tvalid),
        .tready    (axis.m_axis_tready)
    );

    assign axis.busy = (state == S_GRANT) | out_vld;

endmodule

// File: tb/tb_axis_src_arbiter.sv
module tb_axis_src_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axis_src_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(32)) if4 ();
    axis_src_arbiter_if #(.NUM_SRC(3), .DATA_WIDTH(32)) if3 ();

    axis_src_arbiter #(.DATA_WIDTH(32), .NUM_SRC(4), .MAX_BURST(8)) u_arb4 (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .axis          (if4)
    );

    axis_src_arbiter #(.DATA_WIDTH(32), .NUM_SRC(3), .MAX_BURST(8)) u_arb3 (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .axis          (if3)
    );

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] en;
        logic       mrdy;
        logic [3:0] rdy;
        logic       mvld;
        logic [1:0] tid;
        logic       busy;
    } vec_t;

    vec_t tbl[21];

    int         n_chk = 0;
    int         n_err = 0;
    int         cnt4[4];
    int         cnt3[3];
    bit         upd;
    logic [3:0] acc4;
    logic [2:0] acc3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_val(input int src, input int n);
        return 32'hA000_0000 + 32'(src << 16) + 32'(n);
    endfunction

    task automatic set_data();
        for (int i = 0; i < 4; i++)
            if4.s_axis_tdata[i*32 +: 32] = upd ? beat_val(i, cnt4[i]) : 32'hD000_0000 + 32'(i);
        for (int i = 0; i < 3; i++)
            if3.s_axis_tdata[i*32 +: 32] = upd ? beat_val(i, cnt3[i]) : 32'hD000_0000 + 32'(i);
    endtask

    task automatic to_neg();
        @(negedge clk);
        acc4 = if4.s_axis_tvalid & if4.s_axis_tready;
        acc3 = if3.s_axis_tvalid & if3.s_axis_tready;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc4[i] === 1'b1) cnt4[i]++;
        for (int i = 0; i < 3; i++) if (acc3[i] === 1'b1) cnt3[i]++;
        set_data();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if4.s_axis_tvalid = '0; if4.src_en = '0; if4.m_axis_tready = 1'b0;
        if3.s_axis_tvalid = '0; if3.src_en = '0; if3.m_axis_tready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            to_neg();
            to_pos();
        end
        for (int i = 0; i < 4; i++) cnt4[i] = 0;
        for (int i = 0; i < 3; i++) cnt3[i] = 0;
        set_data();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int gap;
        int exp_n;
        int b;
        int etid;
        int ecnt;

        // rst, vld, en, mrdy | rdy, mvld, tid, busy
        tbl[0]  = '{1'b0, 4'b0100, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, 4'b0100, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[3]  = '{1'b0, 4'b0100, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[5]  = '{1'b0, 4'b1001, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'b1001, 4'hF, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1};
        tbl[7]  = '{1'b0, 4'b1001, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1};
        tbl[8]  = '{1'b0, 4'b1001, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1};
        tbl[9]  = '{1'b0, 4'b1001, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[10] = '{1'b0, 4'b0001, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[11] = '{1'b0, 4'b0001, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 4'b0001, 4'hE, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 4'b0001, 4'hE, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 4'b0011, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 4'b0011, 4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1};
        tbl[16] = '{1'b1, 4'b0011, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
        tbl[17] = '{1'b0, 4'b0011, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 4'b0011, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[20] = '{1'b0, 4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

        upd = 1'b0;
        set_data();
        do_reset();

        // Reset state of both instances
        to_neg();
        chk("rst4_mvalid", 32'(if4.m_axis_tvalid), 32'd0);
        chk("rst4_mdata",  if4.m_axis_tdata, 32'd0);
        chk("rst4_mtid",   32'(if4.m_axis_tid), 32'd0);
        chk("rst4_tready", 32'(if4.s_axis_tready), 32'd0);
        chk("rst4_busy",   32'(if4.busy), 32'd0);
        chk("rst3_mvalid", 32'(if3.m_axis_tvalid), 32'd0);
        chk("rst3_tready", 32'(if3.s_axis_tready), 32'd0);
        chk("rst3_busy",   32'(if3.busy), 32'd0);
        to_pos();

        // Table: early release, stall, wrap, enable release, reset mid-burst
        for (int r = 0; r < 21; r++) begin
            rst               = tbl[r].rst;
            if4.s_axis_tvalid = tbl[r].vld;
            if4.src_en        = tbl[r].en;
            if4.m_axis_tready = tbl[r].mrdy;
            to_neg();
            chk($sformatf("tbl%0d_tready", r), 32'(if4.s_axis_tready), 32'(tbl[r].rdy));
            chk($sformatf("tbl%0d_mvalid", r), 32'(if4.m_axis_tvalid), 32'(tbl[r].mvld));
            chk($sformatf("tbl%0d_busy", r),   32'(if4.busy), 32'(tbl[r].busy));
            if (tbl[r].mvld) begin
                chk($sformatf("tbl%0d_tid", r),   32'(if4.m_axis_tid), 32'(tbl[r].tid));
                chk($sformatf("tbl%0d_tdata", r), if4.m_axis_tdata, 32'hD000_0000 + 32'(tbl[r].tid));
            end
            to_pos();
        end
        rst = 1'b0;

        // Fairness: all four sources streaming, bursts of 8 with one gap
        upd = 1'b1;
        do_reset();
        if4.s_axis_tvalid = 4'hF;
        if4.src_en        = 4'hF;
        if4.m_axis_tready = 1'b1;
        k   = 0;
        gap = 0;
        for (int c = 0; c < 50; c++) begin
            to_neg();
            chk("fair_rdy_onehot", 32'($countones(if4.s_axis_tready) <= 1), 32'd1);
            if (if4.m_axis_tvalid === 1'b1) begin
                b    = k / 8;
                etid = b % 4;
                ecnt = (b / 4) * 8 + k % 8;
                chk($sformatf("fair_tid_k%0d", k),  32'(if4.m_axis_tid), 32'(etid));
                chk($sformatf("fair_data_k%0d", k), if4.m_axis_tdata, beat_val(etid, ecnt));
                if (k > 0) chk($sformatf("fair_gap_k%0d", k), 32'(gap), (k % 8 == 0) ? 32'd1 : 32'd0);
                gap = 0;
                k++;
            end else begin
                gap++;
            end
            to_pos();
        end
        chk("fair_beats", 32'(k), 32'd43);

        // Back-pressure: source 1 alone, output stalled for 5 cycles mid-burst
        do_reset();
        if4.s_axis_tvalid = 4'b0010;
        if4.src_en        = 4'hF;
        exp_n = 0;
        for (int c = 0; c < 30; c++) begin
            if4.m_axis_tready = (c >= 6 && c <= 10) ? 1'b0 : 1'b1;
            to_neg();
            if (c >= 6 && c <= 10) begin
                chk($sformatf("bp_hold_valid_c%0d", c), 32'(if4.m_axis_tvalid), 32'd1);
                chk($sformatf("bp_hold_data_c%0d", c),  if4.m_axis_tdata, beat_val(1, 4));
                chk($sformatf("bp_hold_tid_c%0d", c),   32'(if4.m_axis_tid), 32'd1);
                chk($sformatf("bp_hold_rdy_c%0d", c),   32'(if4.s_axis_tready), 32'd0);
            end
            if (c == 15) chk("bp_burst_gap", 32'(if4.m_axis_tvalid), 32'd0);
            if (if4.m_axis_tvalid === 1'b1 && if4.m_axis_tready === 1'b1) begin
                chk($sformatf("bp_tid_n%0d", exp_n),  32'(if4.m_axis_tid), 32'd1);
                chk($sformatf("bp_data_n%0d", exp_n), if4.m_axis_tdata, beat_val(1, exp_n));
                exp_n++;
            end
            to_pos();
        end
        chk("bp_beats", 32'(exp_n), 32'd21);

        // Three sources, source 1 disabled: grants alternate 0, 2, 0, 2
        do_reset();
        if4.s_axis_tvalid = '0;
        if3.s_axis_tvalid = 3'b111;
        if3.src_en        = 3'b101;
        if3.m_axis_tready = 1'b1;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            to_neg();
            if (if3.m_axis_tvalid === 1'b1) begin
                etid = ((k / 8) % 2 == 0) ? 0 : 2;
                ecnt = (k / 16) * 8 + k % 8;
                chk($sformatf("wrap_tid_k%0d", k),  32'(if3.m_axis_tid), 32'(etid));
                chk($sformatf("wrap_data_k%0d", k), if3.m_axis_tdata, beat_val(etid, ecnt));
                k++;
            end
            to_pos();
        end
        chk("wrap_beats", 32'(k), 32'd34);

        // Disable source 0 mid-burst: release next cycle, in-flight beat delivered
        do_reset();
        if3.s_axis_tvalid = 3'b111;
        if3.src_en        = 3'b101;
        if3.m_axis_tready = 1'b1;
        to_neg();
        chk("dis_c0_rdy", 32'(if3.s_axis_tready), 32'd0);
        to_pos();
        to_neg();
        chk("dis_c1_rdy", 32'(if3.s_axis_tready), 32'd1);
        to_pos();
        to_neg();
        chk("dis_c2_valid", 32'(if3.m_axis_tvalid), 32'd1);
        chk("dis_c2_data",  if3.m_axis_tdata, beat_val(0, 0));
        to_pos();
        if3.src_en = 3'b100;
        to_neg();
        chk("dis_c3_rdy",   32'(if3.s_axis_tready), 32'd0);
        chk("dis_c3_valid", 32'(if3.m_axis_tvalid), 32'd1);
        chk("dis_c3_tid",   32'(if3.m_axis_tid), 32'd0);
        chk("dis_c3_data",  if3.m_axis_tdata, beat_val(0, 1));
        to_pos();
        to_neg();
        chk("dis_c4_valid", 32'(if3.m_axis_tvalid), 32'd0);
        chk("dis_c4_rdy",   32'(if3.s_axis_tready), 32'd0);
        to_pos();
        to_neg();
        chk("dis_c5_rdy",   32'(if3.s_axis_tready), 32'd4);
        to_pos();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_src_arbiter.md
# axis_src_arbiter

Round-robin, burst-limited arbiter that shares one 32-bit AXI-stream path (the hotness-address FIFO input) among NUM_SRC producer streams. It holds a grant on one source for up to MAX_BURST beats, registers the selected beat into a one-entry output stage, and tags each beat with its source index. The block sits between the per-channel address monitors and the shared `axis_data_fifo` write side.

## Interface
- DATA_WIDTH, 32, beat width
- NUM_SRC, 4, number of source streams (2..16, need not be a power of two)
- MAX_BURST, 8, maximum beats per grant (1..256)
- ID_WIDTH (localparam), $clog2(NUM_SRC), width of the source tag

- s_axis_aclk  in  1  single clock
- s_axis_areset  in  1  synchronous reset, active-high
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source beats; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tready  out  NUM_SRC  per-source ready; at most one bit high
- src_en  in  NUM_SRC  per-source enable; disabled sources are never granted
- m_axis_tdata  out  DATA_WIDTH  registered output beat
- m_axis_tid  out  ID_WIDTH  source index of m_axis_tdata
- m_axis_tvalid  out  1  registered output valid
- m_axis_tready  in  1  downstream ready
- busy  out  1  state==GRANT or m_axis_tvalid

## Operation
- Output stage free: `free = ~m_axis_tvalid | m_axis_tready`.
- FSM states: IDLE, GRANT. Registers: state, grant_id, rr_ptr, beat_cnt.
- IDLE: req = s_axis_tvalid & src_en. If req != 0, pick the first set bit at index >= rr_ptr, else wrap to the lowest set bit. Then go to GRANT with grant_id = pick and beat_cnt = 0. No beat is accepted in IDLE.
- GRANT: s_axis_tready[grant_id] = free & src_en[grant_id]; all other ready bits are 0. Accept = tvalid & tready on grant_id.
- On accept:
  - load m_axis_tdata/m_axis_tid from the source;
  - set m_axis_tvalid = 1;
  - increment beat_cnt.
- Release GRANT → IDLE when any of the following holds:
  - (a) a beat is accepted while beat_cnt == MAX_BURST-1;
  - (b) s_axis_tvalid[grant_id] == 0;
  - (c) src_en[grant_id] == 0.
- On release, rr_ptr = (grant_id+1) mod NUM_SRC: NUM_SRC-1 wraps to 0, and a non-power-of-two NUM_SRC uses a compare rather than bit truncation.
- While the output is stalled (free == 0) with tvalid still high, the grant is held and beat_cnt is unchanged.
- Output stage: if m_axis_tvalid & m_axis_tready and there is no accept in the same cycle, m_axis_tvalid = 0. A simultaneous drain and accept reloads the stage, and m_axis_tvalid stays 1.
- Once m_axis_tvalid is high, m_axis_tdata and m_axis_tid are stable until m_axis_tready.
- If src_en drops mid-burst, the beat already in the output stage is still delivered.

## Timing
- Reset values:
  - state = IDLE; rr_ptr, grant_id and beat_cnt = 0;
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tid = 0;
  - s_axis_tready = 0, busy = 0.
- Reset mid-operation discards any buffered beat. s_axis_tready is 0 in the reset cycle itself.
- Latency: an accept in cycle N gives m_axis_tvalid = 1 with that beat in cycle N+1.
- Arbitration costs exactly one cycle. The first s_axis_tready is asserted in the cycle after req is seen in IDLE.
- Throughput with m_axis_tready held at 1 and all sources streaming: MAX_BURST beats per MAX_BURST+1 cycles.
- s_axis_tready depends combinationally on m_axis_tready (through free) and on src_en. It never depends on s_axis_tvalid.
- beat_cnt is 8 bits wide; MAX_BURST=256 compares against 255 with no overflow.

## Structure
- Package `axis_arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT};
  - function `rr_pick(req, ptr)` that returns the index, implemented as a generic NUM_SRC loop.
- One sub-module, `axis_out_reg`: the one-entry data/tid/valid output stage with load/drain handshake, reused later by the FIFO read-side mux.
- The top level holds the FSM, the counters and the tdata slice mux.

## Test plan
- Reset mid-burst: source 1 streaming and the output holding a beat; assert s_axis_areset for 1 cycle → m_axis_tvalid = 0, all ready bits 0, and the first grant after reset goes to the lowest requester at or above index 0.
- Fairness: all 4 sources continuously valid, src_en = 4'hF, m_axis_tready = 1, MAX_BURST = 8 → m_axis_tid sequence is 8×0, 8×1, 8×2, 8×3, 8×0…; one idle output cycle between bursts.
- Early release: only source 2 valid, for 3 beats → 3 beats with tid = 2, release on tvalid low, next grant to source 3 on its first request (rr_ptr = 3).
- Back-pressure: m_axis_tready = 0 for 5 cycles mid-burst → m_axis_tvalid held at 1, tdata/tid stable, all s_axis_tready 0, beat_cnt frozen; on release of back-pressure the burst completes with its remaining beats, none lost or duplicated.
- Enable masking and wrap: NUM_SRC = 3, src_en = 3'b101, all sources valid → grants alternate 0, 2, 0, 2. Disable source 0 mid-burst → release next cycle and the in-flight beat is still delivered.
- Simultaneous drain and accept: back-to-back beats with m_axis_tready = 1 → m_axis_tvalid stays 1 across consecutive cycles, data 0xA0000000+n in order with no gaps inside a burst.
